// File: rtl/dtw_src_ctrl.sv
// dtw_src_ctrl: command controller for dtw_core that starts a run, routes the
// core's source reads to the reference or query FIFO and reports the words consumed.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   cmd_valid/cmd_mode/cmd_ref_len        command request (0 = load reference, 1 = run query)
//   cmd_ready                             controller idle, command accepted on valid & ready
//   core_start/core_op_mode/core_ref_len  start pulse and latched command to dtw_core
//   core_running, core_src_rden           dtw_core status and source read strobe
//   core_src_empty, core_src_data         muxed source FIFO flag and data to dtw_core
//   ref_fifo_*, query_fifo_*              reference and query FIFO read ports
//   done, done_words, err_len, err_timeout  completion pulse and held run results
// Optional watchdog: define DTW_SRC_CTRL_TIMEOUT_EN to abort runs after TIMEOUT_CYCLES.
module dtw_src_ctrl #(
   parameter int SQG_SIZE       = 250,
   parameter int REF_SIZE       = 29898,
   parameter int LW             = 15,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic          cmd_mode,
   input  logic [LW-1:0] cmd_ref_len,
   output logic          cmd_ready,
   output logic          core_start,
   output logic          core_op_mode,
   output logic [LW-1:0] core_ref_len,
   input  logic          core_running,
   input  logic          core_src_rden,
   output logic          core_src_empty,
   output logic [31:0]   core_src_data,
   output logic          ref_fifo_rden,
   input  logic          ref_fifo_empty,
   input  logic [31:0]   ref_fifo_dout,
   output logic          query_fifo_rden,
   input  logic          query_fifo_empty,
   input  logic [31:0]   query_fifo_dout,
   output logic          done,
   output logic [LW-1:0] done_words,
   output logic          err_len,
   output logic          err_timeout
);
   typedef enum logic [2:0] {IDLE, START, WAIT_RUN, RUN, DONE} state_t;
   localparam logic [LW-1:0] REF_MAX = LW'(REF_SIZE);
   localparam logic [LW-1:0] SQG_CNT = LW'(SQG_SIZE);
   state_t        state, state_nx;
   logic          accept, active, expired;
   logic          mode_q, res_q;
   logic [LW-1:0] len_q, cnt;
   assign accept = cmd_valid && state == IDLE;
   assign active = state == START || state == WAIT_RUN || state == RUN;
`ifdef DTW_SRC_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          to_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tcnt <= '0;
         to_q <= 1'b0;
      end else if (accept) begin
         tcnt <= '0;
         to_q <= 1'b0;
      end else begin
         if (state == WAIT_RUN || state == RUN) tcnt <= tcnt + TW'(1);
         if (expired) to_q <= 1'b1;
      end
   // fires in the cycle whose increment would reach the limit, so DONE follows on the next edge
   assign expired     = (state == WAIT_RUN || state == RUN) && tcnt == TW'(TIMEOUT_CYCLES - 1);
   assign err_timeout = to_q;
`else
   assign expired     = 1'b0;
   assign err_timeout = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = cmd_valid ? START : IDLE;
         START:    state_nx = WAIT_RUN;
         WAIT_RUN: state_nx = expired ? DONE : (core_running ? RUN : WAIT_RUN);
         RUN:      state_nx = (expired || !core_running) ? DONE : RUN;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end
   always_comb begin
      cmd_ready       = state == IDLE;
      core_start      = state == START;
      done            = state == DONE;
      core_src_empty  = active ? (mode_q ? query_fifo_empty : ref_fifo_empty) : 1'b1;
      core_src_data   = active ? (mode_q ? query_fifo_dout : ref_fifo_dout) : 32'd0;
      ref_fifo_rden   = active && !mode_q && core_src_rden;
      query_fifo_rden = active && mode_q && core_src_rden;
   end
   // core_src_empty is forced high outside active states, so the counter freezes
   // after DONE and doubles as the held done_words value until the next acceptance
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mode_q <= 1'b0;
         len_q  <= REF_MAX;
         cnt    <= '0;
         res_q  <= 1'b0;
      end else if (accept) begin
         mode_q <= cmd_mode;
         len_q  <= (cmd_ref_len == '0 || cmd_ref_len > REF_MAX) ? REF_MAX : cmd_ref_len;
         cnt    <= '0;
         res_q  <= 1'b0;
      end else begin
         if (core_src_rden && !core_src_empty && cnt != '1) cnt <= cnt + LW'(1);
         if (state == DONE) res_q <= 1'b1;
      end
   assign core_op_mode = mode_q;
   assign core_ref_len = len_q;
   assign done_words   = cnt;
   assign err_len      = (res_q || done) && cnt != (mode_q ? SQG_CNT : len_q);
endmodule

// File: tb/tb_dtw_src_ctrl.sv
// tb_dtw_src_ctrl: self-checking bench for dtw_src_ctrl acting as dtw_core and both FIFOs.
module tb_dtw_src_ctrl;
   localparam int LW       = 15;
   localparam int REF_SIZE = 29898;
   localparam int SQG_SIZE = 250;
   localparam int TO       = 64;
   localparam int MAXW     = (1 << LW) - 1;
   logic          clk = 1'b0, rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_mode = 1'b0;
   logic [LW-1:0] cmd_ref_len = '0;
   logic          cmd_ready, core_start, core_op_mode;
   logic [LW-1:0] core_ref_len, done_words;
   logic          core_running = 1'b0, core_src_rden = 1'b0;
   logic          core_src_empty, ref_fifo_rden, query_fifo_rden;
   logic [31:0]   core_src_data;
   logic          ref_fifo_empty = 1'b0, query_fifo_empty = 1'b0;
   logic [31:0]   ref_fifo_dout = 32'h1234_5678, query_fifo_dout = 32'h9abc_def0;
   logic          done, err_len, err_timeout;
   int            checks = 0, errors = 0;
   always #5 clk = ~clk;
   dtw_src_ctrl #(.SQG_SIZE(SQG_SIZE), .REF_SIZE(REF_SIZE), .LW(LW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ref_len(cmd_ref_len),
      .cmd_ready(cmd_ready), .core_start(core_start), .core_op_mode(core_op_mode),
      .core_ref_len(core_ref_len), .core_running(core_running), .core_src_rden(core_src_rden),
      .core_src_empty(core_src_empty), .core_src_data(core_src_data),
      .ref_fifo_rden(ref_fifo_rden), .ref_fifo_empty(ref_fifo_empty), .ref_fifo_dout(ref_fifo_dout),
      .query_fifo_rden(query_fifo_rden), .query_fifo_empty(query_fifo_empty),
      .query_fifo_dout(query_fifo_dout), .done(done), .done_words(done_words),
      .err_len(err_len), .err_timeout(err_timeout));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic int clamp_len(input int len);
      return (len == 0 || len > REF_SIZE) ? REF_SIZE : len;
   endfunction
   // one command: run_delay idle core cycles after START, then n_reads reads of which
   // exactly n_empty hit an empty selected FIFO at random positions
   task automatic do_run(input bit mode, input int len_in, input int exp_len, input int n_reads,
                         input int n_empty, input int run_delay, input bit poke);
      int words, starts, rbad, left, exp_words, exp_err;
      bit e, got;
      logic [31:0] d;
      words = 0; rbad = 0; left = n_empty; got = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_mode = mode; cmd_ref_len = LW'(len_in);
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_mode = ~mode; cmd_ref_len = LW'($urandom);
      @(negedge clk);
      chk("start_pulse", core_start, 1);
      chk("op_mode", core_op_mode, mode);
      chk("ref_len", core_ref_len, exp_len);
      chk("ready_busy", cmd_ready, 0);
      starts = 1;
      for (int i = 0; i < run_delay; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         starts += int'(core_start);
      end
      for (int i = 0; i < n_reads; i++) begin
         @(posedge clk); #1;
         core_running = 1'b1; core_src_rden = 1'b1;
         e = $urandom_range(n_reads - 1 - i) < left;
         if (e) left--;
         d = $urandom;
         if (mode) begin
            query_fifo_empty = e; query_fifo_dout = d;
            ref_fifo_empty = 1'($urandom); ref_fifo_dout = $urandom;
         end else begin
            ref_fifo_empty = e; ref_fifo_dout = d;
            query_fifo_empty = 1'($urandom); query_fifo_dout = $urandom;
         end
         cmd_valid = poke && i == n_reads / 2;
         @(negedge clk);
         if (!e) words++;
         rbad += int'(core_src_empty !== e) + int'(core_src_data !== d) + int'(cmd_ready !== 1'b0)
               + int'(ref_fifo_rden !== !mode) + int'(query_fifo_rden !== mode)
               + int'(core_op_mode !== mode) + int'(core_ref_len !== LW'(exp_len));
         starts += int'(core_start);
      end
      @(posedge clk); #1;
      core_running = 1'b0; core_src_rden = 1'b0; cmd_valid = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
         else starts += int'(core_start);
      end
      exp_words = words > MAXW ? MAXW : words;
      exp_err   = int'(exp_words != (mode ? SQG_SIZE : exp_len));
      chk("done_seen", got, 1);
      chk("done_words", done_words, exp_words);
      chk("err_len", err_len, exp_err);
      chk("err_timeout", err_timeout, 0);
      chk("routing", rbad, 0);
      chk("start_count", starts, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("ready_after", cmd_ready, 1);
      chk("hold_words", done_words, exp_words);
      chk("hold_err_len", err_len, exp_err);
      chk("idle_empty", core_src_empty, 1);
      chk("idle_data", core_src_data, 0);
   endtask
   typedef struct {
      bit mode;
      int len_in;
      int exp_len;
   } vec_t;
   vec_t tbl[6];
   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end
   initial begin
      bit got;
      int n, m, l;
      tbl[0] = '{0, 0, REF_SIZE};
      tbl[1] = '{0, REF_SIZE, REF_SIZE};
      tbl[2] = '{0, REF_SIZE + 1, REF_SIZE};
      tbl[3] = '{1, MAXW, REF_SIZE};
      tbl[4] = '{1, 1, 1};
      tbl[5] = '{0, 100, 100};
      cmd_valid = 1'b1; core_src_rden = 1'b1; cmd_mode = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_start", core_start, 0);
      chk("rst_done", done, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_ref_rden", ref_fifo_rden, 0);
      chk("rst_query_rden", query_fifo_rden, 0);
      chk("rst_src_empty", core_src_empty, 1);
      chk("rst_op_mode", core_op_mode, 0);
      chk("rst_ref_len", core_ref_len, REF_SIZE);
      chk("rst_done_words", done_words, 0);
      @(posedge clk); #1;
      rst = 1'b0; cmd_valid = 1'b0; core_src_rden = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n = $urandom_range(40, 1);
         do_run(tbl[i].mode, tbl[i].len_in, tbl[i].exp_len, n, $urandom_range(n - 1), $urandom_range(3), 1'b0);
      end
      do_run(1'b0, REF_SIZE, REF_SIZE, REF_SIZE, 0, 1, 1'b0);
      do_run(1'b1, 7, 7, SQG_SIZE + 10, 10, 1, 1'b0);
      do_run(1'b1, 100, 100, 200, 0, 2, 1'b0);
      do_run(1'b0, 0, REF_SIZE, 30, 3, 1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         n = $urandom_range(300, 1);
         m = $urandom_range(n - 1);
         l = $urandom_range(MAXW);
         do_run(1'($urandom), l, clamp_len(l), n, m, $urandom_range(4), 1'($urandom));
      end
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_ref_len = LW'(5);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      query_fifo_empty = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         core_running = 1'b1; core_src_rden = 1'b1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_done", done, 0);
      chk("abort_words", done_words, 0);
      chk("abort_src_empty", core_src_empty, 1);
      chk("abort_query_rden", query_fifo_rden, 0);
      chk("abort_ref_len", core_ref_len, REF_SIZE);
      @(posedge clk); #1;
      rst = 1'b0; core_running = 1'b0; core_src_rden = 1'b0;
      got = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || !cmd_ready) got = 1;
      end
      chk("abort_quiet", got, 0);
`ifdef DTW_SRC_CTRL_TIMEOUT_EN
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_ref_len = LW'(10);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      got = 0; n = 0;
      for (int i = 1; i <= 80 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            n = i;
         end
      end
      chk("timeout_cycle", n, 66);
      chk("timeout_flag", err_timeout, 1);
      chk("timeout_err_len", err_len, 1);
      @(negedge clk);
      chk("timeout_hold", err_timeout, 1);
`endif
      do_run(1'b1, 3, 3, SQG_SIZE, 0, 0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dtw_src_ctrl.md
DTW_SRC_CTRL -- requirements
Module: dtw_src_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- SQG_SIZE, default 250: query samples per run.
- REF_SIZE, default 29898: maximum reference length.
- LW, default 15: width of the length and count fields.
- TIMEOUT_CYCLES, default 1048576: watchdog limit.
REQ-002 The block SHALL have the following ports, in this order:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_mode  in  1  0 = load reference, 1 = run query.
- cmd_ref_len  in  LW  reference length for the run.
- cmd_ready  out  1  controller idle; command accepted when both cmd_valid and cmd_ready are high.
- core_start  out  1  start pulse to dtw_core.
- core_op_mode  out  1  latched mode.
- core_ref_len  out  LW  latched length.
- core_running  in  1  dtw_core busy.
- core_src_rden  in  1  dtw_core source read.
- core_src_empty  out  1  muxed empty flag.
- core_src_data  out  32  muxed data.
- ref_fifo_rden  out  1  reference FIFO read.
- ref_fifo_empty  in  1  reference FIFO empty.
- ref_fifo_dout  in  32  reference FIFO data.
- query_fifo_rden  out  1  query FIFO read.
- query_fifo_empty  in  1  query FIFO empty.
- query_fifo_dout  in  32  query FIFO data.
- done  out  1  one-cycle completion pulse.
- done_words  out  LW  words consumed by the run.
- err_len  out  1  word-count mismatch.
- err_timeout  out  1  watchdog expired.

Function
REQ-003 The FSM SHALL have states IDLE, START, WAIT_RUN, RUN, DONE, and its transitions SHALL be:
- IDLE to START on command acceptance.
- START to WAIT_RUN after exactly one cycle.
- WAIT_RUN to RUN when core_running=1.
- RUN to DONE when core_running=0.
- DONE to IDLE after exactly one cycle.
REQ-004 cmd_ready SHALL be 1 only in IDLE.
REQ-005 On acceptance, cmd_mode and cmd_ref_len SHALL be latched; a cmd_ref_len of 0 or above REF_SIZE SHALL be latched as REF_SIZE.
REQ-006 core_start SHALL be 1 only in START, i.e. exactly one cycle, starting one cycle after acceptance.
REQ-007 core_op_mode and core_ref_len SHALL be driven from the latched values and SHALL hold stable from START until the return to IDLE.
REQ-008 In START, WAIT_RUN and RUN, source routing SHALL be combinational from the latched mode:
- Mode 0: core_src_empty=ref_fifo_empty, core_src_data=ref_fifo_dout, ref_fifo_rden=core_src_rden, query_fifo_rden=0.
- Mode 1: the same connections using the query FIFO, with ref_fifo_rden=0.
REQ-009 In IDLE and DONE: core_src_empty=1, both FIFO rden outputs=0, core_src_data=0.
REQ-010 The word counter SHALL clear on acceptance, increment on each cycle with core_src_rden=1 and selected empty=0, and saturate at 2^LW-1.
REQ-011 A read attempted on an empty selected FIFO SHALL not be counted and SHALL still be forwarded.
REQ-012 In DONE: done=1, done_words=counter value, and err_len=1 if the counter differs from the expected count (latched length for mode 0, SQG_SIZE for mode 1).
REQ-013 done_words, err_len and err_timeout SHALL hold until the next acceptance.
REQ-014 cmd_valid SHALL be ignored outside IDLE; no command queueing.

Reset
REQ-015 While rst=1, the block SHALL be in IDLE with all of the following:
- cmd_ready=1.
- core_start, done, err_len, err_timeout, ref_fifo_rden, query_fifo_rden=0.
- core_src_empty=1.
- core_op_mode=0, core_ref_len=REF_SIZE.
- done_words=0, counter=0.
REQ-016 Reset asserted mid-run SHALL abort immediately with no done pulse.

Configuration
REQ-017 With DTW_SRC_CTRL_TIMEOUT_EN defined:
- A cycle counter SHALL clear on acceptance and increment in WAIT_RUN and RUN.
- On reaching TIMEOUT_CYCLES, the FSM SHALL go to DONE with err_timeout=1, regardless of core_running.
REQ-018 Without DTW_SRC_CTRL_TIMEOUT_EN, err_timeout SHALL be constant 0, no watchdog logic SHALL exist, and WAIT_RUN/RUN SHALL wait indefinitely.

Verification
REQ-019 Reset mid-RUN (after 100 reads): the next cycle shows IDLE, cmd_ready=1, done=0, done_words=0.
REQ-020 Mode-0 command with cmd_ref_len=29898; model core raises running 2 cycles after start and reads 29898 words: core_start high exactly 1 cycle, only ref_fifo_rden toggles, done pulse with done_words=29898, err_len=0.
REQ-021 Mode-1 command; core reads 250 words with query_fifo_empty=1 for 10 of the read cycles: done_words=250 counts only non-empty reads, ref_fifo_rden stays 0.
REQ-022 Mode-1 command; core reads 200 words, then drops running: done_words=200, err_len=1.
REQ-023 cmd_ref_len=0: core_ref_len=29898. cmd_valid pulsed during RUN: ignored, no second start.
REQ-024 With DTW_SRC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=64; core never raises running: done at cycle 66 after acceptance, err_timeout=1.
